// File: rtl/secure_reg_access_ctrl.sv
// Access controller for a small bank of sensitive registers shared by a trusted
// HW capture path and a privilege/lock-gated SW port with a timed unlock key.
module secure_reg_access_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 4,
  parameter int                ADDR_W      = 2,
  parameter logic [DATA_W-1:0] UNLOCK_KEY  = 32'hA5C3_5A3C,
  parameter int                KEY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hw_req,
  input  logic [ADDR_W-1:0]          hw_addr,
  input  logic [DATA_W-1:0]          hw_wdata,
  output logic                       hw_gnt,
  input  logic                       sw_req,
  input  logic                       sw_we,
  input  logic                       sw_priv,
  input  logic                       sw_key,
  input  logic [ADDR_W-1:0]          sw_addr,
  input  logic [DATA_W-1:0]          sw_wdata,
  output logic                       sw_gnt,
  output logic [DATA_W-1:0]          sw_rdata,
  output logic                       sw_err,
  output logic [NUM_REGS-1:0]        lock_vec,
  output logic [NUM_REGS*DATA_W-1:0] data_out
);

  localparam int TW = $clog2(KEY_TIMEOUT + 1);

  typedef enum logic {IDLE, ARMED} key_state_t;

  key_state_t                       state, state_nxt;
  logic [TW-1:0]                    timer, timer_nxt;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic                             rr_hw;
  logic                             hw_acc, sw_acc;
  logic                             sw_wr_en, lock_set, lock_clr;
  logic                             err_nxt;
  logic [DATA_W-1:0]                rdata_nxt;

  assign data_out = regs;

  // Round-robin: a requester whose grant is still high cannot be re-accepted.
  always_comb begin
    hw_acc = hw_req && !hw_gnt && (!(sw_req && !sw_gnt) || rr_hw);
    sw_acc = sw_req && !sw_gnt && !hw_acc;
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    sw_wr_en  = 1'b0;
    lock_set  = 1'b0;
    lock_clr  = 1'b0;

    if (state == ARMED) begin
      timer_nxt = timer - TW'(1);
      if (timer == TW'(1)) state_nxt = IDLE;
    end

    if (sw_acc) begin
      if (sw_key) begin
        if (!sw_priv) begin
          err_nxt = 1'b1;
        end else if (!sw_we) begin
          lock_set = 1'b1;
        end else if (state == IDLE) begin
          if (sw_wdata == UNLOCK_KEY) begin
            state_nxt = ARMED;
            timer_nxt = TW'(KEY_TIMEOUT);
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          // Any second key word ends the sequence, right or wrong.
          state_nxt = IDLE;
          timer_nxt = '0;
          if (sw_wdata == ~UNLOCK_KEY) lock_clr = 1'b1;
          else                         err_nxt  = 1'b1;
        end
      end else if (sw_we) begin
        if (sw_priv && !lock_vec[sw_addr]) sw_wr_en = 1'b1;
        else                               err_nxt  = 1'b1;
      end else begin
        if (sw_priv || !lock_vec[sw_addr]) rdata_nxt = regs[sw_addr];
        else                               err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_gnt   <= 1'b0;
      sw_gnt   <= 1'b0;
      sw_err   <= 1'b0;
      sw_rdata <= '0;
      rr_hw    <= 1'b1;
    end else begin
      hw_gnt   <= hw_acc;
      sw_gnt   <= sw_acc;
      sw_err   <= err_nxt;
      sw_rdata <= rdata_nxt;
      if (hw_acc)      rr_hw <= 1'b0;
      else if (sw_acc) rr_hw <= 1'b1;
    end
  end

  // Reads sample regs before this edge's write, so a read sees the prior commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      lock_vec <= '1;
    end else begin
      if (hw_acc)        regs[hw_addr] <= hw_wdata;
      else if (sw_wr_en) regs[sw_addr] <= sw_wdata;
      if (lock_set)      lock_vec[sw_addr] <= 1'b1;
      else if (lock_clr) lock_vec[sw_addr] <= 1'b0;
    end
  end

endmodule
